// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
//   state_t : FSM encodings (2'd3 is unused and recovers to IDLE)
//   clog2   : ceiling log2 for sizing parameters and counters
package rr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between requesting engines and the arbiter.
//   enable    : active-low arbiter enable
//   req       : one active-high request per requester
//   done      : owner release pulse
//   grant_n   : active-low one-hot grant
//   grant_idx : index of current/last owner
//   busy      : high while a grant is held
//   timeout   : one-cycle pulse on a hold-limit revocation
// modport master is the arbiter side; modport slave is the requester side.
interface rr_decoder_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) ();

  logic             enable;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant_n;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             timeout;

  modport master (
    input  enable, req, done,
    output grant_n, grant_idx, busy, timeout
  );

  modport slave (
    output enable, req, done,
    input  grant_n, grant_idx, busy, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: rotate req so ptr lands at bit 0, take the lowest set
// bit, then rotate the offset back into an absolute requester index.
//   req   : request vector
//   ptr   : highest-priority index for this pick
//   valid : at least one request is set
//   idx   : winning requester index (0 when valid is low)
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned SW = IDX_W + 1;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [SW-1:0]    sum;

  // Rotate right by ptr (mod N).
  always_comb begin
    rot = '0;
    for (int i = 0; i < int'(N); i++) begin
      rot[i] = req[IDX_W'((int'(ptr) + i) % int'(N))];
    end
  end

  // Lowest set bit wins; scanning downward leaves the lowest one last.
  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  // Rotate back: (ptr + off) mod N without a divider.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one decoder-selected resource among N
// requesters, with active-low one-hot grants and a hold-time limit.
// Ownership runs IDLE -> GRANT -> RELEASE -> IDLE.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : request/grant bundle (master side)
module rr_decoder_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = clog2(N),
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_decoder_arbiter_if.master bus
);

  localparam int unsigned HOLD_W = clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N-1:0]     grant_n;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             timeout;

  logic             pick_valid_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             early_exit_c;
  logic             expire_c;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid_c),
    .idx   (pick_idx_c)
  );

  // Owner-initiated or enable-forced release outranks hold expiry.
  assign early_exit_c = bus.done | bus.enable | ~bus.req[grant_idx];
  assign expire_c     = (hold_cnt == HOLD_LAST);

  // Ownership FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_n   <= '1;
      grant_idx <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.enable && pick_valid_c) begin
            state     <= ST_GRANT;
            grant_idx <= pick_idx_c;
            grant_n   <= ~(N'(1) << pick_idx_c);
            hold_cnt  <= '0;
            busy      <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (early_exit_c || expire_c) begin
            state   <= ST_RELEASE;
            grant_n <= '1;
            busy    <= 1'b0;
            timeout <= ~early_exit_c;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
          ptr   <= (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
        end
        default: begin
          state   <= ST_IDLE;
          grant_n <= '1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_n   = grant_n;
  assign bus.grant_idx = grant_idx;
  assign bus.busy      = busy;
  assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter (N=4, MAX_HOLD=8).
module tb_rr_decoder_arbiter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  rr_decoder_arbiter_if #(.N(4), .IDX_W(2)) bus ();

  rr_decoder_arbiter #(
    .N        (4),
    .IDX_W    (2),
    .MAX_HOLD (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.req    = 4'b0000;
    bus.done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Tick until a grant appears; cycles = number of all-high cycles seen.
  task automatic wait_grant(output int cycles);
    cycles = 0;
    while (bus.grant_n === 4'b1111 && cycles < 20) begin
      cycles++;
      tick();
    end
    if (bus.grant_n === 4'b1111) begin
      tests++;
      fails++;
      $display("FAIL wait_grant: no grant after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.req    = 4'b0000;
    bus.done   = 1'b0;
    tick();
    tests++; if (bus.grant_n !== 4'b1111) begin fails++; $display("FAIL rst_grant_n: got %b want 1111", bus.grant_n); end
    tests++; if (bus.grant_idx !== 2'd0) begin fails++; $display("FAIL rst_grant_idx: got %0d want 0", bus.grant_idx); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b want 0", bus.timeout); end
    reset   = 1'b0;
    bus.req = 4'b0100;
    tick();
    tests++; if (bus.grant_n !== 4'b1011) begin fails++; $display("FAIL rst_first_grant: got %b want 1011", bus.grant_n); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rst_first_busy: got %b want 1", bus.busy); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    bus.req = 4'b1111;
    tick();
    tests++; if (bus.grant_n !== 4'b0111) begin fails++; $display("FAIL rst_ptr3_grant: got %b want 0111", bus.grant_n); end
    // Asynchronous reset in the middle of a grant.
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.grant_n !== 4'b1111) begin fails++; $display("FAIL rst_async_grant_n: got %b want 1111", bus.grant_n); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_async_busy: got %b want 0", bus.busy); end
    tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL rst_async_timeout: got %b want 0", bus.timeout); end
    tick();
    reset = 1'b0;
    tick();
    tests++; if (bus.grant_idx !== 2'd0) begin fails++; $display("FAIL rst_ptr_cleared: got idx %0d want 0", bus.grant_idx); end
    bus.req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx [5];
    logic [3:0] exp_gn;
    int gap;
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(gap);
      exp_gn = ~(4'b0001 << exp_idx[k]);
      tests++; if (bus.grant_idx !== exp_idx[k]) begin fails++; $display("FAIL rr_idx[%0d]: got %0d want %0d", k, bus.grant_idx, exp_idx[k]); end
      tests++; if (bus.grant_n !== exp_gn) begin fails++; $display("FAIL rr_grant_n[%0d]: got %b want %b", k, bus.grant_n, exp_gn); end
      if (k > 0) begin
        tests++; if (gap != 2) begin fails++; $display("FAIL rr_gap[%0d]: got %0d want 2", k, gap); end
      end
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0010;
    tick();
    for (int i = 0; i < 8; i++) begin
      tests++; if (bus.grant_n !== 4'b1101 || bus.timeout !== 1'b0) begin fails++; $display("FAIL to_hold[%0d]: got gn=%b to=%b want gn=1101 to=0", i, bus.grant_n, bus.timeout); end
      tick();
    end
    tests++; if (bus.timeout !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", bus.timeout); end
    tests++; if (bus.grant_n !== 4'b1111) begin fails++; $display("FAIL to_revoked: got %b want 1111", bus.grant_n); end
    tick();
    tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_width: got %b want 0", bus.timeout); end
    tests++; if (bus.grant_idx !== 2'd1) begin fails++; $display("FAIL to_idx_hold: got %0d want 1", bus.grant_idx); end
    tick();
    tests++; if (bus.grant_n !== 4'b1101) begin fails++; $display("FAIL to_regrant: got %b want 1101", bus.grant_n); end
    bus.req = 4'b0000;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    bus.req = 4'b0100;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0011;
    tick();
    tick();
    tests++; if (bus.grant_idx !== 2'd0) begin fails++; $display("FAIL wrap_idx: got %0d want 0", bus.grant_idx); end
    tests++; if (bus.grant_n !== 4'b1110) begin fails++; $display("FAIL wrap_grant_n: got %b want 1110", bus.grant_n); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tick();
    tests++; if (bus.grant_n !== 4'b1101) begin fails++; $display("FAIL skip_grant_n: got %b want 1101", bus.grant_n); end
    bus.req = 4'b0000;
  endtask

  task automatic test_disable();
    do_reset();
    bus.req = 4'b1000;
    tick();
    tests++; if (bus.grant_n !== 4'b0111) begin fails++; $display("FAIL dis_grant: got %b want 0111", bus.grant_n); end
    bus.enable = 1'b1;
    tick();
    tests++; if (bus.grant_n !== 4'b1111 || bus.timeout !== 1'b0) begin fails++; $display("FAIL dis_release: got gn=%b to=%b want gn=1111 to=0", bus.grant_n, bus.timeout); end
    tick();
    tick();
    tick();
    tests++; if (bus.grant_n !== 4'b1111 || bus.busy !== 1'b0) begin fails++; $display("FAIL dis_no_grant: got gn=%b busy=%b want 1111/0", bus.grant_n, bus.busy); end
    bus.enable = 1'b0;
    tick();
    tests++; if (bus.grant_n !== 4'b0111) begin fails++; $display("FAIL dis_reenable: got %b want 0111", bus.grant_n); end
    bus.req = 4'b0000;
  endtask

  task automatic test_corner();
    do_reset();
    bus.req = 4'b0001;
    tick();
    for (int i = 0; i < 7; i++) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL corner_done_wins: got timeout %b want 0", bus.timeout); end
    tests++; if (bus.grant_n !== 4'b1111) begin fails++; $display("FAIL corner_release: got %b want 1111", bus.grant_n); end
    tick();
    tick();
    tests++; if (bus.grant_n !== 4'b1110) begin fails++; $display("FAIL corner_regrant: got %b want 1110", bus.grant_n); end
    bus.req = 4'b0000;
    tick();
    tests++; if (bus.grant_n !== 4'b1111 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin fails++; $display("FAIL corner_withdraw: got gn=%b busy=%b to=%b want 1111/0/0", bus.grant_n, bus.busy, bus.timeout); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_wrap_skip();
    test_disable();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
